// File: rtl/rv32_mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data load/store.
// Data wins arbitration; a saturating starvation counter forces fetch through after STARVE_LIMIT data grants.
module rv32_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read_in,
  input  logic [31:0] instr_address_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  output logic        instr_fault_out,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [31:0] data_address_in,
  input  logic [31:0] data_write_value_in,
  input  logic [3:0]  data_write_mask_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic        data_fault_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_address_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_wmask_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in,
  input  logic        bus_err_in
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, INSTR, DATA, RESP} state_t;

  state_t      state_q, state_d;
  logic        aborted_q, aborted_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_address_q, bus_address_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wmask_q, bus_wmask_d;
  logic        instr_ready_q, instr_ready_d;
  logic        instr_fault_q, instr_fault_d;
  logic [31:0] instr_value_q, instr_value_d;
  logic        data_ready_q, data_ready_d;
  logic        data_fault_q, data_fault_d;
  logic [31:0] data_value_q, data_value_d;
  logic        data_req;
  logic        fetch_win;
  logic        abort_now;

  assign data_req  = data_read_in | data_write_in;
  assign fetch_win = instr_read_in & (~data_req | (starve_cnt_q == LIMIT));

  always_comb begin
    state_d        = state_q;
    aborted_d      = aborted_q;
    starve_cnt_d   = starve_cnt_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_address_d  = bus_address_q;
    bus_wdata_d    = bus_wdata_q;
    bus_wmask_d    = bus_wmask_q;
    instr_ready_d  = 1'b0;
    instr_fault_d  = 1'b0;
    instr_value_d  = instr_value_q;
    data_ready_d   = 1'b0;
    data_fault_d   = 1'b0;
    data_value_d   = data_value_q;
    abort_now      = aborted_q;

    case (state_q)
      IDLE: begin
        if (!instr_read_in) starve_cnt_d = '0;
        if (fetch_win) begin
          state_d       = INSTR;
          aborted_d     = 1'b0;
          starve_cnt_d  = '0;
          bus_req_d     = 1'b1;
          bus_we_d      = 1'b0;
          bus_address_d = instr_address_in;
          bus_wdata_d   = '0;
          bus_wmask_d   = '0;
        end else if (data_req) begin
          state_d       = DATA;
          aborted_d     = 1'b0;
          bus_req_d     = 1'b1;
          bus_we_d      = data_write_in;
          bus_address_d = data_address_in;
          bus_wdata_d   = data_write_in ? data_write_value_in : '0;
          bus_wmask_d   = data_write_in ? data_write_mask_in : 4'b0000;
          if (instr_read_in && starve_cnt_q < LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      INSTR, DATA: begin
        // A requester that drops its request mid-cycle no longer wants the result.
        abort_now = aborted_q | ((state_q == INSTR) ? ~instr_read_in : ~data_req);
        aborted_d = abort_now;
        if (bus_ack_in || bus_err_in) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
          if (!abort_now) begin
            if (state_q == INSTR) begin
              instr_ready_d = 1'b1;
              instr_fault_d = bus_err_in;
              instr_value_d = bus_err_in ? '0 : bus_rdata_in;
            end else begin
              data_ready_d = 1'b1;
              data_fault_d = bus_err_in;
              data_value_d = (bus_err_in || bus_we_q) ? '0 : bus_rdata_in;
            end
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      aborted_q     <= 1'b0;
      starve_cnt_q  <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_address_q <= '0;
      bus_wdata_q   <= '0;
      bus_wmask_q   <= '0;
      instr_ready_q <= 1'b0;
      instr_fault_q <= 1'b0;
      instr_value_q <= '0;
      data_ready_q  <= 1'b0;
      data_fault_q  <= 1'b0;
      data_value_q  <= '0;
    end else begin
      state_q       <= state_d;
      aborted_q     <= aborted_d;
      starve_cnt_q  <= starve_cnt_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_address_q <= bus_address_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_wmask_q   <= bus_wmask_d;
      instr_ready_q <= instr_ready_d;
      instr_fault_q <= instr_fault_d;
      instr_value_q <= instr_value_d;
      data_ready_q  <= data_ready_d;
      data_fault_q  <= data_fault_d;
      data_value_q  <= data_value_d;
    end
  end

  assign bus_req_out          = bus_req_q;
  assign bus_we_out           = bus_we_q;
  assign bus_address_out      = bus_address_q;
  assign bus_wdata_out        = bus_wdata_q;
  assign bus_wmask_out        = bus_wmask_q;
  assign instr_ready_out      = instr_ready_q;
  assign instr_fault_out      = instr_fault_q;
  assign instr_read_value_out = instr_value_q;
  assign data_ready_out       = data_ready_q;
  assign data_fault_out       = data_fault_q;
  assign data_read_value_out  = data_value_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: directed per-cycle vector table, starvation ordering
// sequence, then randomized requesters/slave checked against a transaction-level model.
module tb_rv32_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_read_in;
  logic [31:0] instr_address_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic        instr_fault_out;
  logic        data_read_in;
  logic        data_write_in;
  logic [31:0] data_address_in;
  logic [31:0] data_write_value_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic        data_fault_out;
  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_address_out;
  logic [31:0] bus_wdata_out;
  logic [3:0]  bus_wmask_out;
  logic        bus_ack_in;
  logic [31:0] bus_rdata_in;
  logic        bus_err_in;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_read_in       (instr_read_in),
    .instr_address_in    (instr_address_in),
    .instr_read_value_out(instr_read_value_out),
    .instr_ready_out     (instr_ready_out),
    .instr_fault_out     (instr_fault_out),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_address_in     (data_address_in),
    .data_write_value_in (data_write_value_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_read_value_out (data_read_value_out),
    .data_ready_out      (data_ready_out),
    .data_fault_out      (data_fault_out),
    .bus_req_out         (bus_req_out),
    .bus_we_out          (bus_we_out),
    .bus_address_out     (bus_address_out),
    .bus_wdata_out       (bus_wdata_out),
    .bus_wmask_out       (bus_wmask_out),
    .bus_ack_in          (bus_ack_in),
    .bus_rdata_in        (bus_rdata_in),
    .bus_err_in          (bus_err_in)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs applied during a cycle, and outputs expected at the start of that same cycle.
  typedef struct {
    logic [31:0] rst, ir, ia, dr, dw, da, dwv, dm, ack, err, rd;
    logic [31:0] zero, e_breq, e_bwe, e_baddr, e_bmask, e_irdy, e_ifault, e_ival, e_drdy, e_dfault, e_dval;
  } vec_t;

  vec_t tbl[$];

  task automatic apply_vec(input vec_t v);
    reset               = v.rst[0];
    instr_read_in       = v.ir[0];
    instr_address_in    = v.ia;
    data_read_in        = v.dr[0];
    data_write_in       = v.dw[0];
    data_address_in     = v.da;
    data_write_value_in = v.dwv;
    data_write_mask_in  = v.dm[3:0];
    bus_ack_in          = v.ack[0];
    bus_err_in          = v.err[0];
    bus_rdata_in        = v.rd;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    if (v.zero != 0) begin
      check($sformatf("row%0d reset outputs", i),
            32'({bus_req_out, bus_we_out, bus_wmask_out, instr_ready_out, instr_fault_out, data_ready_out, data_fault_out}), 0);
      check($sformatf("row%0d reset addr", i), bus_address_out, 0);
      check($sformatf("row%0d reset wdata", i), bus_wdata_out, 0);
      check($sformatf("row%0d reset ival", i), instr_read_value_out, 0);
      check($sformatf("row%0d reset dval", i), data_read_value_out, 0);
    end else begin
      check($sformatf("row%0d bus_req", i), 32'(bus_req_out), v.e_breq);
      if (v.e_breq != 0) begin
        check($sformatf("row%0d bus_we", i), 32'(bus_we_out), v.e_bwe);
        check($sformatf("row%0d bus_addr", i), bus_address_out, v.e_baddr);
        check($sformatf("row%0d bus_mask", i), 32'(bus_wmask_out), v.e_bmask);
      end
      check($sformatf("row%0d instr_ready", i), 32'(instr_ready_out), v.e_irdy);
      check($sformatf("row%0d instr_fault", i), 32'(instr_fault_out), v.e_ifault);
      check($sformatf("row%0d instr_value", i), instr_read_value_out, v.e_ival);
      check($sformatf("row%0d data_ready", i), 32'(data_ready_out), v.e_drdy);
      check($sformatf("row%0d data_fault", i), 32'(data_fault_out), v.e_dfault);
      check($sformatf("row%0d data_value", i), data_read_value_out, v.e_dval);
    end
  endtask

  task automatic inputs_zero();
    instr_read_in = 0; instr_address_in = 0;
    data_read_in = 0; data_write_in = 0; data_address_in = 0;
    data_write_value_in = 0; data_write_mask_in = 0;
    bus_ack_in = 0; bus_err_in = 0; bus_rdata_in = 0;
  endtask

  // Transaction-level reference: at most one transaction owns the bus; it completes on the
  // first ack/err, answers in the following cycle, and the bus is free the cycle after.
  bit          m_busy, m_done, m_abort, m_data, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_mask;
  int          m_starve;
  logic        x_irdy, x_ifault, x_drdy, x_dfault;
  logic [31:0] x_ival, x_dval;

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_abort = 0; m_data = 0; m_we = 0;
    m_addr = 0; m_wdata = 0; m_mask = 0; m_starve = 0;
    x_irdy = 0; x_ifault = 0; x_drdy = 0; x_dfault = 0; x_ival = 0; x_dval = 0;
  endtask

  task automatic m_step();
    bit dreq;
    bit pick_i, pick_d;
    dreq = data_read_in | data_write_in;
    x_irdy = 0; x_ifault = 0; x_drdy = 0; x_dfault = 0;
    if (m_busy && m_done) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (m_data ? !dreq : !instr_read_in) m_abort = 1;
      if (bus_ack_in || bus_err_in) begin
        m_done = 1;
        if (!m_abort && m_data) begin
          x_drdy = 1; x_dfault = bus_err_in;
          x_dval = (bus_err_in || m_we) ? 32'h0 : bus_rdata_in;
        end else if (!m_abort) begin
          x_irdy = 1; x_ifault = bus_err_in;
          x_ival = bus_err_in ? 32'h0 : bus_rdata_in;
        end
      end
    end else begin
      pick_i = instr_read_in && (!dreq || m_starve == LIMIT);
      pick_d = !pick_i && dreq;
      if (!instr_read_in || pick_i) m_starve = 0;
      else if (pick_d && m_starve < LIMIT) m_starve = m_starve + 1;
      if (pick_i || pick_d) begin
        m_busy = 1; m_done = 0; m_abort = 0; m_data = pick_d;
        m_we    = pick_d && data_write_in;
        m_addr  = pick_d ? data_address_in : instr_address_in;
        m_wdata = m_we ? data_write_value_in : 32'h0;
        m_mask  = m_we ? data_write_mask_in : 4'h0;
      end
    end
  endtask

  bit          i_act, d_act, i_wd, d_wd;
  int          kind;
  bit          prev_req;
  bit          grants[$];
  logic [9:0]  got_order;
  bit          x_breq;

  initial begin
    reset = 1;
    inputs_zero();

    // rst ir ia dr dw da dwv dm ack err rd | zero breq bwe baddr bmask irdy ifault ival drdy dfault dval
    tbl.push_back('{0,1,'h100,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,'h100,0,0,0,0,0,1,0,'h13,              0,1,0,'h100,0,0,0,0,0,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,1,0,'h13,0,0,0});
    tbl.push_back('{0,1,'h104,0,1,'h2000,'hdeadbeef,'hf,0,0,0, 0,0,0,0,0,0,0,'h13,0,0,0});
    tbl.push_back('{0,1,'h104,0,1,'h2000,'hdeadbeef,'hf,1,0,0, 0,1,1,'h2000,'hf,0,0,'h13,0,0,0});
    tbl.push_back('{0,1,'h104,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,'h13,1,0,0});
    tbl.push_back('{0,1,'h104,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,'h13,0,0,0});
    tbl.push_back('{0,1,'h104,0,0,0,0,0,1,0,'h00500093,        0,1,0,'h104,0,0,0,'h13,0,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,1,0,'h00500093,0,0,0});
    tbl.push_back('{0,0,0,1,0,'h3004,0,0,0,0,0,                0,0,0,0,0,0,0,'h00500093,0,0,0});
    tbl.push_back('{0,0,0,1,0,'h3004,0,0,1,0,'h11223344,       0,1,0,'h3004,0,0,0,'h00500093,0,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,0,'h00500093,1,0,'h11223344});
    tbl.push_back('{0,0,0,1,0,'h3000,0,0,0,0,0,                0,0,0,0,0,0,0,'h00500093,0,0,'h11223344});
    tbl.push_back('{0,0,0,1,0,'h3000,0,0,0,0,0,                0,1,0,'h3000,0,0,0,'h00500093,0,0,'h11223344});
    tbl.push_back('{0,0,0,1,0,'h3000,0,0,0,0,0,                0,1,0,'h3000,0,0,0,'h00500093,0,0,'h11223344});
    tbl.push_back('{0,0,0,1,0,'h3000,0,0,0,0,0,                0,1,0,'h3000,0,0,0,'h00500093,0,0,'h11223344});
    tbl.push_back('{0,0,0,1,0,'h3000,0,0,1,1,'hcafef00d,       0,1,0,'h3000,0,0,0,'h00500093,0,0,'h11223344});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,0,'h00500093,1,1,0});
    tbl.push_back('{0,1,'h200,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,'h00500093,0,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,0,0,                     0,1,0,'h200,0,0,0,'h00500093,0,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,1,0,'h77,                  0,1,0,'h200,0,0,0,'h00500093,0,0,0});
    tbl.push_back('{0,0,0,1,0,'h40,0,0,0,0,0,                  0,0,0,0,0,0,0,'h00500093,0,0,0});
    tbl.push_back('{0,0,0,1,0,'h40,0,0,0,0,0,                  0,0,0,0,0,0,0,'h00500093,0,0,0});
    tbl.push_back('{0,0,0,1,0,'h40,0,0,1,0,'h55,               0,1,0,'h40,0,0,0,'h00500093,0,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,0,'h00500093,1,0,'h55});
    tbl.push_back('{0,0,0,1,0,'h80,0,0,0,0,0,                  0,0,0,0,0,0,0,'h00500093,0,0,'h55});
    tbl.push_back('{0,0,0,1,0,'h80,0,0,0,0,0,                  0,1,0,'h80,0,0,0,'h00500093,0,0,'h55});
    tbl.push_back('{1,0,0,1,0,'h80,0,0,0,0,0,                  0,1,0,'h80,0,0,0,'h00500093,0,0,'h55});
    tbl.push_back('{0,0,0,0,0,0,0,0,1,0,'h99,                  1,0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,0,0,                     1,0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,0,0,                     1,0,0,0,0,0,0,0,0,0,0});

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      #1;
      check_vec(i, tbl[i]);
      apply_vec(tbl[i]);
      @(posedge clk);
    end

    // Continuous loads against a held fetch with a zero-wait slave.
    #1;
    reset = 1;
    inputs_zero();
    @(posedge clk);
    #1;
    reset = 0;
    instr_read_in = 1; instr_address_in = 32'h1000;
    data_read_in = 1;  data_address_in = 32'h2000;
    prev_req = 0;
    for (int n = 0; n < 45; n++) begin
      @(posedge clk);
      #1;
      if (bus_req_out && !prev_req) grants.push_back(bus_address_out == 32'h1000);
      prev_req = bus_req_out;
      bus_ack_in = bus_req_out;
      bus_rdata_in = 32'(n);
    end
    check("starve grant count", 32'(grants.size() >= 10), 1);
    got_order = '0;
    for (int i = 0; i < 10 && i < grants.size(); i++) got_order[i] = grants[i];
    check("starve grant order", 32'(got_order), 32'h210);

    // Randomized requesters and slave against the reference model.
    reset = 1;
    inputs_zero();
    @(posedge clk);
    #1;
    reset = 0;
    m_reset();
    i_act = 0; d_act = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      x_breq = m_busy && !m_done;
      check($sformatf("rnd%0d bus_req", n), 32'(bus_req_out), 32'(x_breq));
      if (x_breq) begin
        check($sformatf("rnd%0d bus_addr", n), bus_address_out, m_addr);
        check($sformatf("rnd%0d bus_we", n), 32'(bus_we_out), 32'(m_we));
        check($sformatf("rnd%0d bus_mask", n), 32'(bus_wmask_out), 32'(m_mask));
        if (m_we) check($sformatf("rnd%0d bus_wdata", n), bus_wdata_out, m_wdata);
      end
      check($sformatf("rnd%0d pulses", n),
            32'({instr_ready_out, instr_fault_out, data_ready_out, data_fault_out}),
            32'({x_irdy, x_ifault, x_drdy, x_dfault}));
      check($sformatf("rnd%0d instr_value", n), instr_read_value_out, x_ival);
      check($sformatf("rnd%0d data_value", n), data_read_value_out, x_dval);

      i_wd = 0;
      if (i_act && instr_ready_out) i_act = 0;
      else if (i_act && $urandom_range(19) == 0) begin i_act = 0; i_wd = 1; end
      if (!i_act && !i_wd && $urandom_range(2) == 0) begin
        i_act = 1;
        instr_address_in = $urandom & 32'hffff_fffc;
      end
      instr_read_in = i_act;

      d_wd = 0;
      if (d_act && data_ready_out) d_act = 0;
      else if (d_act && $urandom_range(19) == 0) begin d_act = 0; d_wd = 1; end
      if (!d_act && !d_wd && $urandom_range(1) == 0) begin
        d_act = 1;
        kind = int'($urandom_range(2));
        data_read_in        = (kind != 1);
        data_write_in       = (kind != 0);
        data_address_in     = $urandom & 32'hffff_fffc;
        data_write_value_in = $urandom;
        data_write_mask_in  = 4'($urandom_range(15));
      end
      if (!d_act) begin data_read_in = 0; data_write_in = 0; end

      if (bus_req_out) begin
        bus_ack_in = ($urandom_range(1) == 0);
        bus_err_in = ($urandom_range(5) == 0);
      end else begin
        bus_ack_in = ($urandom_range(7) == 0);
        bus_err_in = ($urandom_range(11) == 0);
      end
      bus_rdata_in = $urandom;

      m_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
